agt_responder: RTL
==================

# agt_responder

Synthesizable responder for the `agt` request/response interface: the memory-mapped target that the `agt` agent's driver initiates transactions against. It accepts one read or write request at a time and applies a fixed, parameterized number of wait states. Writes go to and reads come from an internal register array, and each request produces a single response. It sits at the DUT end of the `agt` interface, as the counterpart of the UVM agent in loopback and agent self-test benches.

## Interface
- `ADDR_W`, 8: request address width.
- `DATA_W`, 32: data width.
- `DEPTH`, 16: number of register words. Must be a power of two and ≤ 2^ADDR_W.
- `LATENCY`, 2: wait-state cycles between request accept and response. Range is 0..15.

- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: word address.
- `req_wdata` in DATA_W: write data.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: initiator accepts response.
- `rsp_rdata` out DATA_W: read data; 0 for writes.
- `rsp_err` out 1: address error.

## Operation
- **FSM states.** The FSM has three states: IDLE, WAIT and RESP.
- **IDLE.**
  - `req_ready`=1.
  - On `req_valid && req_ready`:
    - Latch `req_write`/`req_addr`.
    - A write commits `req_wdata` to the array at this edge.
    - Load the wait counter with `LATENCY`.
    - Go to WAIT, or go directly to RESP if `LATENCY`=0.
- **WAIT.**
  - `req_ready`=0.
  - The counter decrements each cycle. Counter width is `$clog2(LATENCY+1)`, minimum 1.
  - Transition to RESP on the cycle the counter reaches 1.
  - Response fields are registered on the transition into RESP:
    - Reads: `rsp_rdata` = array[addr].
    - Writes: `rsp_rdata` = 0.
- **RESP.**
  - `rsp_valid`=1; `rsp_rdata` and `rsp_err` are held stable until handshake.
  - On `rsp_valid && rsp_ready`: go to IDLE and clear `rsp_valid`, `rsp_rdata` and `rsp_err`.
- **Ordering and outstanding requests.**
  - Only one transaction is ever outstanding.
  - A read following a write to the same address returns the new data.
- **Reset.**
  - Values: state=IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, all array words=0, counter=0.
  - Reset in WAIT or RESP discards the in-flight transaction; no response is issued.
- **`req_valid` outside IDLE.** Ignored; the initiator must hold it per the handshake.

## Timing
- If a request handshake occurs in cycle c, `rsp_valid` first rises in cycle c+1+`LATENCY`.
- If the response handshake occurs in cycle r, `req_ready` is high in cycle r+1.
- Maximum throughput is one transaction per `LATENCY`+2 cycles, with `rsp_ready` tied high.
- Backpressure: `rsp_ready` low extends RESP indefinitely with no change to outputs.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- **Macro:** `AGT_RESPONDER_ADDR_CHECK_EN`.
- **Defined:** an address ≥ `DEPTH` is an error.
  - A write is dropped and the array is unchanged.
  - A read returns `rsp_rdata`=0.
  - `rsp_err`=1 in the response.
  - Timing is identical to a normal transaction.
- **Undefined:** the index is `req_addr` modulo `DEPTH` (low `$clog2(DEPTH)` bits), so addresses alias. `rsp_err` is tied to 0.

## Test plan
- **Write/read round trip.**
  - Stimulus: reset, then write 0xDEADBEEF to addr 3, then read addr 3.
  - Required: the write response has `rdata`=0 and `err`=0; the read response has `rdata`=0xDEADBEEF.
  - Required: a read of addr 4 returns 0.
- **Latency.**
  - Stimulus: run with `LATENCY`=0 and with `LATENCY`=2, `rsp_ready`=1, and back-to-back reads.
  - Required: `rsp_valid` arrives at c+1 and c+3 respectively.
  - Required: accept-to-accept spacing is 2 and 4 cycles respectively.
- **Backpressure.**
  - Stimulus: read with `rsp_ready`=0 for 5 cycles after `rsp_valid` rises.
  - Required: `rsp_valid`, `rsp_rdata` and `rsp_err` stay constant and `req_ready` stays 0.
  - Required: the response completes on the first cycle `rsp_ready`=1.
- **Out-of-range address, macro defined.**
  - Stimulus: write 0x1234 to addr 16, then read addr 16, then read addr 0 (`DEPTH`=16).
  - Required: both addr-16 responses have `err`=1, and the read returns 0.
  - Required: the addr-0 read returns 0.
- **Out-of-range address, macro undefined.**
  - Stimulus: the same sequence as above.
  - Required: the write lands at addr 0, and both reads return 0x1234 with `err`=0.
- **Reset mid-transaction.**
  - Stimulus: assert `rst` for one cycle in WAIT, with `LATENCY`=3, after a read request.
  - Required: no `rsp_valid` ever appears for that request.
  - Required: `req_ready`=1 immediately after reset.
  - Required: the next read of a previously written address returns 0.

Source files
------------

// File: rtl/agt_responder.sv
// Memory-mapped target for the agt request/response interface: one transaction in flight, LATENCY wait states.
// Optional address range checking is enabled by defining AGT_RESPONDER_ADDR_CHECK_EN.
module agt_responder #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 16,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              write_q;
    logic              err_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              enter_resp;
    logic              req_err;
    logic [IDX_W-1:0]  req_idx;
    logic              sel_write;
    logic              sel_err;
    logic [IDX_W-1:0]  sel_idx;
    logic              unused_addr_bits;

    assign req_idx          = req_addr[IDX_W-1:0];
    assign unused_addr_bits = ^req_addr;
`ifdef AGT_RESPONDER_ADDR_CHECK_EN
    assign req_err = ({1'b0, req_addr} >= (ADDR_W + 1)'(DEPTH));
`else
    assign req_err = 1'b0;
`endif

    assign accept     = (state == IDLE) && req_valid;
    assign enter_resp = (state != RESP) && (state_nxt == RESP);

    // With LATENCY=0 the response is built straight from the request being accepted.
    assign sel_write = (state == IDLE) ? req_write : write_q;
    assign sel_err   = (state == IDLE) ? req_err   : err_q;
    assign sel_idx   = (state == IDLE) ? req_idx   : idx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (req_valid) state_nxt = (LATENCY == 0) ? RESP : WAIT;
            WAIT:    if (cnt == CNT_W'(1)) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            cnt     <= CNT_W'(LATENCY);
            write_q <= req_write;
            err_q   <= req_err;
            idx_q   <= req_idx;
        end else if (state == WAIT) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (accept && req_write && !req_err) begin
            mem[req_idx] <= req_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (enter_resp) begin
            rsp_rdata <= (sel_write || sel_err) ? '0 : mem[sel_idx];
            rsp_err   <= sel_err;
        end else if (state == RESP && rsp_ready) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end
    end
endmodule
